// File: rtl/pc_sequencer_if.sv
// Control/IM-facing signal bundle of the fetch-stage PC sequencer.
// The master modport drives the requests. The slave modport (the sequencer) drives the PC and status.
interface pc_sequencer_if;
    logic        stall;
    logic        imem_ready;
    logic        jump;
    logic [31:0] jump_addr;
    logic        branch;
    logic [31:0] branch_addr;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        fetch_valid;
    logic        fetch_adel;
    logic        pend_valid;

    modport master (
        output stall, imem_ready, jump, jump_addr, branch, branch_addr,
               exc_req, eret_req, epc,
        input  pc, pc_4, fetch_valid, fetch_adel, pend_valid
    );

    modport slave (
        input  stall, imem_ready, jump, jump_addr, branch, branch_addr,
               exc_req, eret_req, epc,
        output pc, pc_4, fetch_valid, fetch_adel, pend_valid
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and next-PC sequencing: exception, ERET, redirects, stall and +4.
// Redirects that arrive while fetch is held are latched and applied on the next advancing cycle.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PC_LOW     = 32'h0000_3000,
    parameter logic [31:0] PC_HIGH    = 32'h0000_6ffc
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic        adel_q, adel_d;
    logic        advance;

    assign advance = bus.imem_ready & ~bus.stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            pend_addr_q  <= 32'h0;
            pend_valid_q <= 1'b0;
            adel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            adel_q       <= adel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;

        unique case (state_q)
            StBoot: state_d = StRun;
            StRun, StPend: begin
                if (bus.exc_req) begin
                    pc_d         = EXC_VECTOR;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (bus.eret_req) begin
                    pc_d         = bus.epc;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (!advance) begin
                    // Newest redirect overwrites any earlier pending one.
                    if (bus.jump) begin
                        pend_addr_d  = bus.jump_addr;
                        pend_valid_d = 1'b1;
                        state_d      = StPend;
                    end else if (bus.branch) begin
                        pend_addr_d  = bus.branch_addr;
                        pend_valid_d = 1'b1;
                        state_d      = StPend;
                    end
                end else if (bus.jump) begin
                    pc_d         = bus.jump_addr;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (bus.branch) begin
                    pc_d         = bus.branch_addr;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (pend_valid_q) begin
                    pc_d         = pend_addr_q;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: state_d = StBoot;
        endcase

        // Illegal targets are still loaded; only the AdEL flag reports them.
        adel_d = (pc_d[1:0] != 2'b00) | (pc_d < PC_LOW) | (pc_d > PC_HIGH);
    end

    assign bus.pc          = pc_q;
    assign bus.pc_4        = pc_q + 32'd4;
    assign bus.fetch_adel  = adel_q;
    assign bus.pend_valid  = pend_valid_q;
    assign bus.fetch_valid = (state_q != StBoot) & bus.imem_ready & ~adel_q;

endmodule
